d_phy_clk_lane_ctrl: RTL and testbench

Sequencer for the MIPI D-PHY v2.5 master clock lane behavioural model. It walks the clock lane through the LP-to-HS entry sequence, continuous HS clocking, and the HS-to-LP exit sequence in response to a high-speed request. Its outputs gate the word-rate clock that drives lane toggling and set the LP line levels, so the lane models stay free of sequencing logic. It runs in the word-clock domain; every timing interval is an integer count of word-clock cycles.

---
 rtl/csi_param_pkg.sv | 35 +++
 rtl/d_phy_interval_cnt.sv | 30 +++
 rtl/d_phy_clk_lane_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_d_phy_clk_lane_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/csi_param_pkg.sv
// Shared constants and types for the D-PHY clock lane sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package csi_param_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Default interval lengths, in word-clock cycles
  localparam int T_LPX_DEF         = 2;
  localparam int T_CLK_PREPARE_DEF = 3;
  localparam int T_CLK_ZERO_DEF    = 10;
  localparam int T_CLK_PRE_DEF     = 4;
  localparam int T_CLK_POST_DEF    = 8;
  localparam int T_CLK_TRAIL_DEF   = 3;
  localparam int T_HS_EXIT_DEF     = 4;

  typedef enum logic [3:0] {
    STOP      = 4'd0,
    HS_RQST   = 4'd1,
    HS_PREP   = 4'd2,
    HS_ZERO   = 4'd3,
    HS_PRE    = 4'd4,
    HS_ACTIVE = 4'd5,
    HS_POST   = 4'd6,
    HS_TRAIL  = 4'd7,
    HS_EXIT   = 4'd8
  } clk_lane_state_t;

  // A zero-length interval is stretched to one cycle so every state is visited.
  function automatic int eff_len(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/d_phy_interval_cnt.sv
// Down-counter timing one sequencer interval; done while the count reads 0.
// Latency: load takes effect on the next edge; done is decoded from the register.
// Backpressure: none; decrement stops at 0 so the count never wraps.
module d_phy_interval_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load on state entry, otherwise count down and hold at zero
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/d_phy_clk_lane_ctrl.sv
// D-PHY master clock lane sequencer: LP->HS entry, HS clocking, HS->LP exit.
// Latency: outputs are registered from the state register (one cycle behind state).
// Backpressure: none; entry and exit sequences always run to completion.
module d_phy_clk_lane_ctrl
  import csi_param_pkg::*;
#(
  parameter int T_LPX         = T_LPX_DEF,
  parameter int T_CLK_PREPARE = T_CLK_PREPARE_DEF,
  parameter int T_CLK_ZERO    = T_CLK_ZERO_DEF,
  parameter int T_CLK_PRE     = T_CLK_PRE_DEF,
  parameter int T_CLK_POST    = T_CLK_POST_DEF,
  parameter int T_CLK_TRAIL   = T_CLK_TRAIL_DEF,
  parameter int T_HS_EXIT     = T_HS_EXIT_DEF,
  parameter int CNT_W         = 8
) (
  input  logic hs_tx_word_clk,
  input  logic rst_n,
  input  logic tx_request_hs,
  output logic tx_ready_hs,
  output logic stop_state,
  output logic lp_dp,
  output logic lp_dn,
  output logic hs_en,
  output logic clk_gate_en
);

  // Counter load values: a state of length N loads N-1 and leaves when it reads 0
  localparam logic [CNT_W-1:0] L_LPX   = CNT_W'(eff_len(T_LPX) - 1);
  localparam logic [CNT_W-1:0] L_PREP  = CNT_W'(eff_len(T_CLK_PREPARE) - 1);
  localparam logic [CNT_W-1:0] L_ZERO  = CNT_W'(eff_len(T_CLK_ZERO) - 1);
  localparam logic [CNT_W-1:0] L_PRE   = CNT_W'(eff_len(T_CLK_PRE) - 1);
  localparam logic [CNT_W-1:0] L_POST  = CNT_W'(eff_len(T_CLK_POST) - 1);
  localparam logic [CNT_W-1:0] L_TRAIL = CNT_W'(eff_len(T_CLK_TRAIL) - 1);
  localparam logic [CNT_W-1:0] L_EXIT  = CNT_W'(eff_len(T_HS_EXIT) - 1);

  clk_lane_state_t  r_state;
  clk_lane_state_t  w_next_state;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;

  logic w_tx_ready_hs;
  logic w_stop_state;
  logic w_lp_dp;
  logic w_lp_dn;
  logic w_hs_en;
  logic w_clk_gate_en;

  logic r_tx_ready_hs;
  logic r_stop_state;
  logic r_lp_dp;
  logic r_lp_dn;
  logic r_hs_en;
  logic r_clk_gate_en;

  d_phy_interval_cnt #(
    .CNT_W (CNT_W)
  ) u_interval_cnt (
    .i_clk      (hs_tx_word_clk),
    .i_rst_n    (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (!w_load),
    .o_done     (w_done)
  );

  // State register
  always_ff @(posedge hs_tx_word_clk) begin
    if (!rst_n) begin
      r_state <= STOP;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state; every transition into a timed state loads that state's interval
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      STOP: begin
        if (tx_request_hs) begin
          w_next_state = HS_RQST;
          w_load       = 1'b1;
          w_load_val   = L_LPX;
        end
      end
      HS_RQST: begin
        if (w_done) begin
          w_next_state = HS_PREP;
          w_load       = 1'b1;
          w_load_val   = L_PREP;
        end
      end
      HS_PREP: begin
        if (w_done) begin
          w_next_state = HS_ZERO;
          w_load       = 1'b1;
          w_load_val   = L_ZERO;
        end
      end
      HS_ZERO: begin
        if (w_done) begin
          w_next_state = HS_PRE;
          w_load       = 1'b1;
          w_load_val   = L_PRE;
        end
      end
      HS_PRE: begin
        if (w_done) begin
          w_next_state = HS_ACTIVE;
        end
      end
      HS_ACTIVE: begin
        // A request that dropped during entry is seen here after one cycle
        if (!tx_request_hs) begin
          w_next_state = HS_POST;
          w_load       = 1'b1;
          w_load_val   = L_POST;
        end
      end
      HS_POST: begin
        if (w_done) begin
          w_next_state = HS_TRAIL;
          w_load       = 1'b1;
          w_load_val   = L_TRAIL;
        end
      end
      HS_TRAIL: begin
        if (w_done) begin
          w_next_state = HS_EXIT;
          w_load       = 1'b1;
          w_load_val   = L_EXIT;
        end
      end
      HS_EXIT: begin
        // Requests arriving during exit are only honoured from STOP
        if (w_done) begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_next_state = STOP;
      end
    endcase
  end

  // Per-state output decode; LP lines are driven low whenever the HS driver is on
  always_comb begin
    w_tx_ready_hs = LOW;
    w_stop_state  = LOW;
    w_lp_dp       = LOW;
    w_lp_dn       = LOW;
    w_hs_en       = LOW;
    w_clk_gate_en = LOW;
    case (r_state)
      STOP: begin
        w_stop_state = HIGH;
        w_lp_dp      = HIGH;
        w_lp_dn      = HIGH;
      end
      HS_RQST: begin
        w_lp_dn = HIGH;
      end
      HS_PREP: begin
        w_lp_dp = LOW;
      end
      HS_ZERO, HS_TRAIL: begin
        w_hs_en = HIGH;
      end
      HS_PRE, HS_POST: begin
        w_hs_en       = HIGH;
        w_clk_gate_en = HIGH;
      end
      HS_ACTIVE: begin
        w_hs_en       = HIGH;
        w_clk_gate_en = HIGH;
        w_tx_ready_hs = HIGH;
      end
      HS_EXIT: begin
        w_lp_dp = HIGH;
        w_lp_dn = HIGH;
      end
      default: begin
        w_stop_state = HIGH;
        w_lp_dp      = HIGH;
        w_lp_dn      = HIGH;
      end
    endcase
  end

  // Output registers; reset forces LP-11 stop immediately with no exit sequence
  always_ff @(posedge hs_tx_word_clk) begin
    if (!rst_n) begin
      r_tx_ready_hs <= LOW;
      r_stop_state  <= HIGH;
      r_lp_dp       <= HIGH;
      r_lp_dn       <= HIGH;
      r_hs_en       <= LOW;
      r_clk_gate_en <= LOW;
    end else begin
      r_tx_ready_hs <= w_tx_ready_hs;
      r_stop_state  <= w_stop_state;
      r_lp_dp       <= w_lp_dp;
      r_lp_dn       <= w_lp_dn;
      r_hs_en       <= w_hs_en;
      r_clk_gate_en <= w_clk_gate_en;
    end
  end

  assign tx_ready_hs = r_tx_ready_hs;
  assign stop_state  = r_stop_state;
  assign lp_dp       = r_lp_dp;
  assign lp_dn       = r_lp_dn;
  assign hs_en       = r_hs_en;
  assign clk_gate_en = r_clk_gate_en;

endmodule

// File: tb/tb_d_phy_clk_lane_ctrl.sv
// Bench for d_phy_clk_lane_ctrl: default instance plus one with T_CLK_PRE=0, T_HS_EXIT=0.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_d_phy_clk_lane_ctrl;

  // Output vector order: {tx_ready_hs, stop_state, lp_dp, lp_dn, hs_en, clk_gate_en}
  localparam logic [5:0] O_STOP = 6'b011100;
  localparam logic [5:0] O_RQ   = 6'b000100;
  localparam logic [5:0] O_PR   = 6'b000000;
  localparam logic [5:0] O_ZE   = 6'b000010;
  localparam logic [5:0] O_PRE  = 6'b000011;
  localparam logic [5:0] O_ACT  = 6'b100011;
  localparam logic [5:0] O_POST = 6'b000011;
  localparam logic [5:0] O_TR   = 6'b000010;
  localparam logic [5:0] O_EX   = 6'b001100;

  typedef struct {
    int         cyc;
    logic       rst_n;
    logic       req;
    logic [5:0] exp_a;
    logic [5:0] exp_z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req = 1'b1;

  logic rdy_a, stop_a, dp_a, dn_a, hs_a, gate_a;
  logic rdy_z, stop_z, dp_z, dn_z, hs_z, gate_z;
  logic [5:0] got_a, got_z;

  int checks = 0;
  int errors = 0;
  int cyc = -1;
  vec_t vq[$];

  assign got_a = {rdy_a, stop_a, dp_a, dn_a, hs_a, gate_a};
  assign got_z = {rdy_z, stop_z, dp_z, dn_z, hs_z, gate_z};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  d_phy_clk_lane_ctrl u_dut_a (
    .hs_tx_word_clk (clk),
    .rst_n          (rst_n),
    .tx_request_hs  (req),
    .tx_ready_hs    (rdy_a),
    .stop_state     (stop_a),
    .lp_dp          (dp_a),
    .lp_dn          (dn_a),
    .hs_en          (hs_a),
    .clk_gate_en    (gate_a)
  );

  d_phy_clk_lane_ctrl #(
    .T_CLK_PRE (0),
    .T_HS_EXIT (0)
  ) u_dut_z (
    .hs_tx_word_clk (clk),
    .rst_n          (rst_n),
    .tx_request_hs  (req),
    .tx_ready_hs    (rdy_z),
    .stop_state     (stop_z),
    .lp_dp          (dp_z),
    .lp_dn          (dn_z),
    .hs_en          (hs_z),
    .clk_gate_en    (gate_z)
  );

  task automatic add(input int c, input logic r, input logic q,
                     input logic [5:0] a, input logic [5:0] z);
    vec_t v;
    v.cyc = c; v.rst_n = r; v.req = q; v.exp_a = a; v.exp_z = z;
    vq.push_back(v);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int vi;
    int first_rdy_a, first_rdy_z, first_stop_a, first_stop_z, rdy_width_a;

    // Reset held with request high, release at 3 (entry k=3)
    add(0, 0, 1, O_STOP, O_STOP);
    add(1, 0, 1, O_STOP, O_STOP);
    add(2, 0, 1, O_STOP, O_STOP);
    add(3, 1, 1, O_STOP, O_STOP);
    add(4, 1, 1, O_RQ,   O_RQ);
    add(5, 1, 1, O_RQ,   O_RQ);
    add(6, 1, 1, O_PR,   O_PR);
    add(8, 1, 1, O_PR,   O_PR);
    add(9, 1, 1, O_ZE,   O_ZE);
    add(18, 1, 1, O_ZE,  O_ZE);
    add(19, 1, 1, O_PRE, O_PRE);
    add(20, 1, 1, O_PRE, O_ACT);
    add(22, 1, 1, O_PRE, O_ACT);
    add(23, 1, 1, O_ACT, O_ACT);
    // Exit: request low sampled at 40, reasserted at the gate fall (49)
    add(40, 1, 0, O_ACT,  O_ACT);
    add(41, 1, 0, O_POST, O_POST);
    add(48, 1, 0, O_POST, O_POST);
    add(49, 1, 1, O_TR,   O_TR);
    add(51, 1, 1, O_TR,   O_TR);
    add(52, 1, 1, O_EX,   O_EX);
    add(53, 1, 1, O_EX,   O_STOP);
    add(54, 1, 1, O_EX,   O_RQ);
    add(55, 1, 1, O_EX,   O_RQ);
    add(56, 1, 1, O_STOP, O_PR);
    add(57, 1, 1, O_RQ,   O_PR);
    add(58, 1, 1, O_RQ,   O_PR);
    add(59, 1, 1, O_PR,   O_ZE);
    // Early drop during entry: entry completes, one ACTIVE cycle, then exit
    add(60, 1, 0, O_PR,   O_ZE);
    add(61, 1, 0, O_PR,   O_ZE);
    add(62, 1, 0, O_ZE,   O_ZE);
    add(68, 1, 0, O_ZE,   O_ZE);
    add(69, 1, 0, O_ZE,   O_PRE);
    add(70, 1, 0, O_ZE,   O_ACT);
    add(71, 1, 0, O_ZE,   O_POST);
    add(72, 1, 0, O_PRE,  O_POST);
    add(75, 1, 0, O_PRE,  O_POST);
    add(76, 1, 0, O_ACT,  O_POST);
    add(77, 1, 0, O_POST, O_POST);
    add(78, 1, 0, O_POST, O_POST);
    add(79, 1, 0, O_POST, O_TR);
    add(82, 1, 0, O_POST, O_EX);
    add(83, 1, 0, O_POST, O_STOP);
    add(84, 1, 0, O_POST, O_STOP);
    add(85, 1, 0, O_TR,   O_STOP);
    add(88, 1, 0, O_EX,   O_STOP);
    add(91, 1, 0, O_EX,   O_STOP);
    add(92, 1, 0, O_STOP, O_STOP);
    // Reset mid-entry at 110, then a fresh entry from k=111
    add(100, 1, 1, O_STOP, O_STOP);
    add(101, 1, 1, O_RQ,   O_RQ);
    add(103, 1, 1, O_PR,   O_PR);
    add(106, 1, 1, O_ZE,   O_ZE);
    add(109, 1, 1, O_ZE,   O_ZE);
    add(110, 0, 1, O_STOP, O_STOP);
    add(111, 1, 1, O_STOP, O_STOP);
    add(112, 1, 1, O_RQ,   O_RQ);
    add(113, 1, 1, O_RQ,   O_RQ);
    add(114, 1, 1, O_PR,   O_PR);

    vi = 0;
    for (int c = 0; c <= 114; c++) begin
      if (vi < vq.size() && vq[vi].cyc == c) begin
        rst_n = vq[vi].rst_n;
        req   = vq[vi].req;
      end
      @(posedge clk);
      #1;
      if (vi < vq.size() && vq[vi].cyc == c) begin
        checks++;
        if (got_a !== vq[vi].exp_a) begin
          errors++;
          $display("FAIL dflt@%0d: got %b expected %b", c, got_a, vq[vi].exp_a);
        end
        checks++;
        if (got_z !== vq[vi].exp_z) begin
          errors++;
          $display("FAIL zero@%0d: got %b expected %b", c, got_z, vq[vi].exp_z);
        end
        vi++;
      end
    end
    check_int("vectors_applied", vi, vq.size());

    // Entry latency from the release at 111: ready at k+20 / k+17
    first_rdy_a = -1;
    first_rdy_z = -1;
    rdy_width_a = 0;
    while (cyc < 139) begin
      @(posedge clk);
      #1;
      if (rdy_a && first_rdy_a < 0) first_rdy_a = cyc;
      if (rdy_z && first_rdy_z < 0) first_rdy_z = cyc;
    end
    check_int("entry_ready_dflt", first_rdy_a, 131);
    check_int("entry_ready_zero", first_rdy_z, 128);

    // Drop request sampled at 140; ready stays through 140 and stop rises at m+16 / m+13
    req = 1'b0;
    if (rdy_a) rdy_width_a = cyc - first_rdy_a + 1;
    first_stop_a = -1;
    first_stop_z = -1;
    while (cyc < 170 && (first_stop_a < 0 || first_stop_z < 0)) begin
      @(posedge clk);
      #1;
      if (rdy_a) rdy_width_a++;
      if (stop_a && first_stop_a < 0) first_stop_a = cyc;
      if (stop_z && first_stop_z < 0) first_stop_z = cyc;
    end
    check_int("ready_width_dflt", rdy_width_a, 10);
    check_int("exit_stop_dflt", first_stop_a, 156);
    check_int("exit_stop_zero", first_stop_z, 153);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
